// File: rtl/cpld_uart_ctrl.sv
// Byte-wide sequencer for the CPLD UART sharing base_ram_data[7:0]: issues
// read/write strobes and exposes synchronized receive/transmit status.
module cpld_uart_ctrl #(
    parameter int RD_PULSE = 2,
    parameter int WR_PULSE = 2,
    parameter int GUARD    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_read,
    input  logic       req_write,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       rx_ready,
    output logic       tx_idle,
    input  logic [7:0] bus_in,
    output logic [7:0] bus_out,
    output logic       bus_oe,
    output logic       uart_rdn,
    output logic       uart_wrn,
    input  logic       uart_dataready,
    input  logic       uart_tbre,
    input  logic       uart_tsre
);

    localparam int GW = (GUARD > 1) ? $clog2(GUARD + 1) : 1;

    typedef enum logic [3:0] {
        IDLE,
        RD_WAIT,
        RD_LOW,
        WR_SETUP,
        WR_LOW,
        WR_HOLD,
        WR_WAIT_TBRE,
        WR_WAIT_TSRE,
        DONE
    } state_t;

    state_t         state_reg;
    logic [2:0]     pulse_cnt_reg;
    logic [GW-1:0]  guard_reg;
    logic [7:0]     rd_data_reg;
    logic [7:0]     wr_byte_reg;
    logic           rdn_reg;
    logic           wrn_reg;
    logic           oe_reg;
    logic           busy_reg;
    logic           done_reg;

    // Status pins are asynchronous to clk; two flops each.
    logic [2:0] async_in;
    logic [2:0] sync_bits;
    assign async_in = {uart_tsre, uart_tbre, uart_dataready};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= async_in[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync_bits[gi] = sync_reg;
        end
    endgenerate

    logic ready_s;
    logic tbre_s;
    logic tsre_s;
    assign ready_s = sync_bits[0];
    assign tbre_s  = sync_bits[1];
    assign tsre_s  = sync_bits[2];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            pulse_cnt_reg <= 3'd0;
            guard_reg     <= '0;
            rd_data_reg   <= 8'h00;
            wr_byte_reg   <= 8'h00;
            rdn_reg       <= 1'b1;
            wrn_reg       <= 1'b1;
            oe_reg        <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_read) begin
                        busy_reg <= 1'b1;
                        if (ready_s) begin
                            state_reg     <= RD_LOW;
                            rdn_reg       <= 1'b0;
                            pulse_cnt_reg <= 3'(RD_PULSE - 1);
                        end else begin
                            state_reg <= RD_WAIT;
                        end
                    end else if (req_write) begin
                        busy_reg    <= 1'b1;
                        oe_reg      <= 1'b1;
                        wr_byte_reg <= wr_data;
                        state_reg   <= WR_SETUP;
                    end
                end
                RD_WAIT: begin
                    if (ready_s) begin
                        state_reg     <= RD_LOW;
                        rdn_reg       <= 1'b0;
                        pulse_cnt_reg <= 3'(RD_PULSE - 1);
                    end
                end
                RD_LOW: begin
                    if (pulse_cnt_reg == 3'd0) begin
                        rdn_reg     <= 1'b1;
                        rd_data_reg <= bus_in;
                        done_reg    <= 1'b1;
                        state_reg   <= DONE;
                    end else begin
                        pulse_cnt_reg <= pulse_cnt_reg - 3'd1;
                    end
                end
                WR_SETUP: begin
                    wrn_reg       <= 1'b0;
                    pulse_cnt_reg <= 3'(WR_PULSE - 1);
                    state_reg     <= WR_LOW;
                end
                WR_LOW: begin
                    if (pulse_cnt_reg == 3'd0) begin
                        wrn_reg   <= 1'b1;
                        guard_reg <= GW'(GUARD);
                        state_reg <= WR_HOLD;
                    end else begin
                        pulse_cnt_reg <= pulse_cnt_reg - 3'd1;
                    end
                end
                // Guard ticks every cycle from the wrn rising edge, so the
                // stale pre-write tbre/tsre levels are ignored for GUARD cycles.
                WR_HOLD: begin
                    oe_reg    <= 1'b0;
                    guard_reg <= guard_reg - GW'(1);
                    state_reg <= WR_WAIT_TBRE;
                end
                WR_WAIT_TBRE: begin
                    if (guard_reg != '0) begin
                        guard_reg <= guard_reg - GW'(1);
                    end else if (tbre_s) begin
                        state_reg <= WR_WAIT_TSRE;
                    end
                end
                WR_WAIT_TSRE: begin
                    if (tsre_s) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    rdn_reg   <= 1'b1;
                    wrn_reg   <= 1'b1;
                    oe_reg    <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign rd_data  = rd_data_reg;
    assign bus_out  = wr_byte_reg;
    assign bus_oe   = oe_reg;
    assign uart_rdn = rdn_reg;
    assign uart_wrn = wrn_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign rx_ready = ready_s;
    assign tx_idle  = tbre_s & tsre_s & (state_reg == IDLE);

endmodule

// File: tb/tb_cpld_uart_ctrl.sv
// Directed bench for cpld_uart_ctrl: cycle-exact read, wait, write, abort,
// back-to-back and status-latency scenarios against hand-derived timelines.
module tb_cpld_uart_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_read;
    logic       req_write;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic       rx_ready;
    logic       tx_idle;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic       uart_rdn;
    logic       uart_wrn;
    logic       uart_dataready;
    logic       uart_tbre;
    logic       uart_tsre;

    int checks = 0;
    int errors = 0;

    cpld_uart_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .req_read       (req_read),
        .req_write      (req_write),
        .wr_data        (wr_data),
        .rd_data        (rd_data),
        .busy           (busy),
        .done           (done),
        .rx_ready       (rx_ready),
        .tx_idle        (tx_idle),
        .bus_in         (bus_in),
        .bus_out        (bus_out),
        .bus_oe         (bus_oe),
        .uart_rdn       (uart_rdn),
        .uart_wrn       (uart_wrn),
        .uart_dataready (uart_dataready),
        .uart_tbre      (uart_tbre),
        .uart_tsre      (uart_tsre)
    );

    always #45 clk = ~clk;

    // Outputs are sampled 1 time unit after the active edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_write = 1'b1; wr_data = 8'h11;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (uart_wrn !== 1'b1) begin errors++; $display("FAIL reset_wrn cyc %0d: got %b want 1", i, uart_wrn); end
            checks++; if (uart_rdn !== 1'b1) begin errors++; $display("FAIL reset_rdn cyc %0d: got %b want 1", i, uart_rdn); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy cyc %0d: got %b want 0", i, busy); end
            checks++; if (bus_oe !== 1'b0) begin errors++; $display("FAIL reset_oe cyc %0d: got %b want 0", i, bus_oe); end
        end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", rd_data); end
        checks++; if (bus_out !== 8'h00) begin errors++; $display("FAIL reset_bus_out: got %h want 00", bus_out); end
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
        checks++; if (tx_idle !== 1'b0) begin errors++; $display("FAIL reset_tx_idle: got %b want 0", tx_idle); end
        rst = 1'b1;
        tick();
        req_write = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_release_busy: got %b want 1", busy); end
        checks++; if (bus_out !== 8'h11) begin errors++; $display("FAIL reset_release_bus_out: got %h want 11", bus_out); end
        for (int i = 0; i < 60 && busy; i++) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_write_timeout: busy got %b want 0", busy); end
        $display("reset: released, first write accepted and completed");
    endtask

    task automatic test_read();
        bus_in = 8'h5A;
        tick(); tick(); tick();
        req_read = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) req_read = 1'b0;
            checks++; if (uart_rdn !== !(c == 1 || c == 2)) begin errors++; $display("FAIL read_rdn T%0d: got %b want %b", c, uart_rdn, !(c == 1 || c == 2)); end
            checks++; if (done !== (c == 3)) begin errors++; $display("FAIL read_done T%0d: got %b want %b", c, done, (c == 3)); end
            checks++; if (busy !== (c <= 3)) begin errors++; $display("FAIL read_busy T%0d: got %b want %b", c, busy, (c <= 3)); end
            if (c >= 3) begin
                checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL read_data T%0d: got %h want 5a", c, rd_data); end
            end
            if (c == 3) bus_in = 8'h00;
        end
        $display("read: rd_data=%h", rd_data);
    endtask

    task automatic test_read_wait();
        uart_dataready = 1'b0; bus_in = 8'h3C;
        tick(); tick(); tick();
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL wait_rx_ready: got %b want 0", rx_ready); end
        req_read = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            tick();
            if (c == 1) req_read = 1'b0;
            checks++; if (uart_rdn !== !(c == 23 || c == 24)) begin errors++; $display("FAIL wait_rdn T%0d: got %b want %b", c, uart_rdn, !(c == 23 || c == 24)); end
            checks++; if (busy !== (c <= 25)) begin errors++; $display("FAIL wait_busy T%0d: got %b want %b", c, busy, (c <= 25)); end
            checks++; if (done !== (c == 25)) begin errors++; $display("FAIL wait_done T%0d: got %b want %b", c, done, (c == 25)); end
            if (c == 20) uart_dataready = 1'b1;
        end
        checks++; if (rd_data !== 8'h3C) begin errors++; $display("FAIL wait_data: got %h want 3c", rd_data); end
        $display("read_wait: rd_data=%h", rd_data);
    endtask

    task automatic test_write();
        wr_data = 8'hA7; req_write = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            tick();
            if (c == 1) begin req_write = 1'b0; wr_data = 8'h00; end
            checks++; if (uart_wrn !== !(c == 2 || c == 3)) begin errors++; $display("FAIL write_wrn T%0d: got %b want %b", c, uart_wrn, !(c == 2 || c == 3)); end
            checks++; if (bus_oe !== (c <= 4)) begin errors++; $display("FAIL write_oe T%0d: got %b want %b", c, bus_oe, (c <= 4)); end
            checks++; if (bus_out !== 8'hA7) begin errors++; $display("FAIL write_bus_out T%0d: got %h want a7", c, bus_out); end
            checks++; if (done !== (c == 24)) begin errors++; $display("FAIL write_done T%0d: got %b want %b", c, done, (c == 24)); end
            checks++; if (busy !== (c <= 24)) begin errors++; $display("FAIL write_busy T%0d: got %b want %b", c, busy, (c <= 24)); end
            checks++; if (tx_idle !== (c >= 25)) begin errors++; $display("FAIL write_tx_idle T%0d: got %b want %b", c, tx_idle, (c >= 25)); end
            checks++; if (uart_rdn !== 1'b1) begin errors++; $display("FAIL write_rdn T%0d: got %b want 1", c, uart_rdn); end
            if (c == 5) begin uart_tbre = 1'b0; uart_tsre = 1'b0; end
            if (c == 15) uart_tbre = 1'b1;
            if (c == 21) uart_tsre = 1'b1;
        end
        $display("write: byte a7 sent");
    endtask

    task automatic test_simultaneous();
        bus_in = 8'h81; wr_data = 8'hFF;
        req_read = 1'b1; req_write = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) begin req_read = 1'b0; req_write = 1'b0; end
            checks++; if (uart_wrn !== 1'b1) begin errors++; $display("FAIL simul_wrn T%0d: got %b want 1", c, uart_wrn); end
            checks++; if (bus_oe !== 1'b0) begin errors++; $display("FAIL simul_oe T%0d: got %b want 0", c, bus_oe); end
            checks++; if (bus_out !== 8'hA7) begin errors++; $display("FAIL simul_bus_out T%0d: got %h want a7", c, bus_out); end
            checks++; if (uart_rdn !== !(c == 1 || c == 2)) begin errors++; $display("FAIL simul_rdn T%0d: got %b want %b", c, uart_rdn, !(c == 1 || c == 2)); end
            checks++; if (done !== (c == 3)) begin errors++; $display("FAIL simul_done T%0d: got %b want %b", c, done, (c == 3)); end
        end
        checks++; if (rd_data !== 8'h81) begin errors++; $display("FAIL simul_data: got %h want 81", rd_data); end
        $display("simultaneous: read won, rd_data=%h", rd_data);
    endtask

    task automatic test_abort();
        wr_data = 8'h5C; req_write = 1'b1;
        tick();
        req_write = 1'b0;
        checks++; if (bus_oe !== 1'b1) begin errors++; $display("FAIL abort_setup_oe: got %b want 1", bus_oe); end
        tick();
        checks++; if (uart_wrn !== 1'b0) begin errors++; $display("FAIL abort_low_wrn: got %b want 0", uart_wrn); end
        rst = 1'b0;
        tick();
        checks++; if (uart_wrn !== 1'b1) begin errors++; $display("FAIL abort_wrn: got %b want 1", uart_wrn); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (bus_oe !== 1'b0) begin errors++; $display("FAIL abort_oe: got %b want 0", bus_oe); end
        checks++; if (bus_out !== 8'h00) begin errors++; $display("FAIL abort_bus_out: got %h want 00", bus_out); end
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done cyc %0d: got %b want 0", c, done); end
            checks++; if (uart_wrn !== 1'b1) begin errors++; $display("FAIL abort_idle_wrn cyc %0d: got %b want 1", c, uart_wrn); end
        end
        $display("abort: write cancelled by reset");
    endtask

    task automatic test_back_to_back();
        bus_in = 8'h42; req_read = 1'b1;
        tick();
        req_read = 1'b0;
        tick(); tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b want 1", done); end
        req_read = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_ignored_busy: got %b want 0", busy); end
        checks++; if (uart_rdn !== 1'b1) begin errors++; $display("FAIL b2b_ignored_rdn: got %b want 1", uart_rdn); end
        tick();
        req_read = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_busy: got %b want 1", busy); end
        checks++; if (uart_rdn !== 1'b0) begin errors++; $display("FAIL b2b_accept_rdn: got %b want 0", uart_rdn); end
        for (int i = 0; i < 20 && busy; i++) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_timeout: busy got %b want 0", busy); end
        checks++; if (rd_data !== 8'h42) begin errors++; $display("FAIL b2b_data: got %h want 42", rd_data); end
        $display("back_to_back: second read accepted after DONE, rd_data=%h", rd_data);
    endtask

    task automatic test_status();
        checks++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL status_init: tx_idle got %b want 1", tx_idle); end
        uart_tbre = 1'b0;
        tick();
        checks++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL status_tbre_fall_1: got %b want 1", tx_idle); end
        tick();
        checks++; if (tx_idle !== 1'b0) begin errors++; $display("FAIL status_tbre_fall_2: got %b want 0", tx_idle); end
        uart_tbre = 1'b1;
        tick();
        checks++; if (tx_idle !== 1'b0) begin errors++; $display("FAIL status_tbre_rise_1: got %b want 0", tx_idle); end
        tick();
        checks++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL status_tbre_rise_2: got %b want 1", tx_idle); end
        uart_tsre = 1'b0;
        tick();
        checks++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL status_tsre_fall_1: got %b want 1", tx_idle); end
        tick();
        checks++; if (tx_idle !== 1'b0) begin errors++; $display("FAIL status_tsre_fall_2: got %b want 0", tx_idle); end
        uart_tsre = 1'b1; uart_dataready = 1'b0;
        tick();
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL status_rx_fall_1: got %b want 1", rx_ready); end
        tick();
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL status_rx_fall_2: got %b want 0", rx_ready); end
        checks++; if (tx_idle !== 1'b1) begin errors++; $display("FAIL status_tsre_rise: got %b want 1", tx_idle); end
        $display("status: tx_idle/rx_ready follow inputs after 2 cycles");
    endtask

    initial begin
        rst = 1'b0; req_read = 1'b0; req_write = 1'b0;
        wr_data = 8'h00; bus_in = 8'h00;
        uart_dataready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b1;
        test_reset();
        test_read();
        test_read_wait();
        test_write();
        test_simultaneous();
        test_abort();
        test_back_to_back();
        test_status();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
